spi_tx_arbiter: RTL and testbench
=================================

# spi_tx_arbiter

Shares one SPI master byte transmitter between the weight stream and the input-activation stream coming from host pipe FIFOs. It grants the transmitter in bursts, by round-robin or strict priority, and counts bytes per source against per-layer totals. It emits 1-cycle per-byte completion pulses that drive the main controller's `weight_tx_data_valid` / `act_in_tx_data_valid` inputs. It sits between the host FIFOs and the SPI master, upstream of the main controller.

## Interface
- `BURST_BYTES`, 16: maximum bytes sent per grant before re-arbitration (≥1).
- `WEIGHT_TOTAL`, 1024: weight bytes per layer.
- `ACT_TOTAL`, 256: input-activation bytes per layer.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  arbitration allowed; sampled only in IDLE.
- `clear`  in  1  1-cycle: zero byte counters, abort to IDLE.
- `w_data`  in  8  weight FIFO head byte (first-word fall-through).
- `w_valid`  in  1  weight FIFO non-empty.
- `w_ready`  out  1  weight FIFO pop (combinational).
- `a_data`  in  8  act-in FIFO head byte.
- `a_valid`  in  1  act-in FIFO non-empty.
- `a_ready`  out  1  act-in FIFO pop (combinational).
- `tx_byte`  out  8  byte to SPI master, held stable until `tx_done`.
- `tx_start`  out  1  1-cycle start pulse to SPI master.
- `tx_done`  in  1  1-cycle pulse: SPI master finished the byte.
- `weight_tx_data_valid`  out  1  1-cycle pulse per completed weight byte.
- `act_in_tx_data_valid`  out  1  1-cycle pulse per completed act-in byte.
- `grant`  out  2  one-hot {act, weight}; 00 when idle.
- `tx_all_done`  out  1  level: both totals reached.

## Operation
- States: IDLE, LOAD, WAIT.
- Eligible source: its `*_valid`=1 and its counter < its total.
- IDLE: if `enable` and at least one source is eligible, latch `grant`, clear `burst_cnt`, go to LOAD.
  - Both eligible: the source the round-robin pointer selects wins.
  - Reset pointer value is weight.
- LOAD: if the granted `*_valid`=1:
  - `*_ready`=1 for this cycle.
  - `tx_byte` <= data; `tx_start` <= 1 (registered, visible next cycle); go to WAIT.
  - Else: `grant` <= 00, go to IDLE.
- WAIT: on `tx_done`:
  - Pulse the granted `*_tx_data_valid` next cycle; increment the source counter and `burst_cnt`.
  - Continue: if `burst_cnt+1` < `BURST_BYTES`, the source is still below its total after the increment, and `*_valid`=1, go to LOAD.
  - Otherwise go to IDLE, set `grant` to 00, and set the pointer to the other source.
- Counters are `$clog2(TOTAL+1)` bits and saturate at the total; no wrap.
- `tx_all_done` = (weight count == `WEIGHT_TOTAL`) && (act count == `ACT_TOTAL`). Cleared only by `clear` or `rst`.
- `clear`:
  - Highest priority in any state: counters, `burst_cnt` and `grant` to 0, go to IDLE, pointer to weight.
  - A `tx_done` arriving in the same cycle is dropped (no valid pulse).
  - A byte already launched on SPI is not recalled.
- `enable` deassertion mid-burst does not stop the burst; it takes effect at the next IDLE.

## Timing
- Reset values: `w_ready`=0, `a_ready`=0, `tx_byte`=0, `tx_start`=0, both valid pulses 0, `grant`=00, `tx_all_done`=0; state IDLE.
- Eligible request in IDLE at cycle N → pop at N+1 → `tx_start` high at N+2.
- `tx_done` at cycle M → `*_tx_data_valid` at M+1.
  - Back-to-back in burst: LOAD at M+1 → next `tx_start` at M+2.
- `tx_start` is exactly 1 cycle wide; at most one byte is in flight.
- `tx_done` outside WAIT is ignored.

## Configuration
- `ARB_STRICT_PRIO_EN` defined:
  - Weight always wins when both sources are eligible; pointer unused.
  - Act-in is granted only when weight is not eligible in IDLE.
- Undefined: round-robin as described in Operation.

## Test plan
- `BURST_BYTES`=4, both FIFOs hold 8 bytes, SPI done 3 cycles after start → grants alternate W,A,W,A in 4-byte bursts. 8 pulses each; `tx_byte` order matches FIFO order.
- `WEIGHT_TOTAL`=5, weight FIFO holds 7 bytes, act empty → exactly 5 weight pulses. Then `w_ready` stays 0 and `grant` stays 00.
- `WEIGHT_TOTAL`=8, `ACT_TOTAL`=8, all 16 bytes sent → `tx_all_done`=1 the cycle after the 16th valid pulse.
- `w_valid` drops after 2 of 4 burst bytes → IDLE after the 2nd byte; `grant` moves to act if act is eligible.
- `clear` coincident with `tx_done` on byte 3 → no pulse, counters 0, IDLE next cycle.
- `rst` asserted in WAIT → all outputs at reset values the next cycle. With `ARB_STRICT_PRIO_EN` and both FIFOs full, all weight bytes are sent before any act byte.

Source files
------------

// File: rtl/spi_tx_arbiter_if.sv
// spi_tx_arbiter_if
// Groups the host FIFO pop handshakes and the SPI master byte handshake that
// spi_tx_arbiter shares between the weight and input-activation streams.
//   w_data/w_valid/w_ready : weight FIFO head byte, non-empty, pop
//   a_data/a_valid/a_ready : act-in FIFO head byte, non-empty, pop
//   tx_byte/tx_start       : byte and 1-cycle start pulse to the SPI master
//   tx_done                : 1-cycle pulse, SPI master finished the byte
// master: arbiter side.  slave: FIFO + SPI master side.
interface spi_tx_arbiter_if;
  logic [7:0] w_data;
  logic       w_valid;
  logic       w_ready;
  logic [7:0] a_data;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       tx_done;

  modport master (
    input  w_data, w_valid, a_data, a_valid, tx_done,
    output w_ready, a_ready, tx_byte, tx_start
  );

  modport slave (
    output w_data, w_valid, a_data, a_valid, tx_done,
    input  w_ready, a_ready, tx_byte, tx_start
  );
endinterface

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter
// Shares one SPI master byte transmitter between the weight stream and the
// input-activation stream. Grants in bursts of up to BURST_BYTES, counts bytes
// per source against per-layer totals and emits 1-cycle completion pulses.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   enable                 : arbitration allowed (sampled in IDLE only)
//   clear                  : 1-cycle, zero counters and abort to IDLE
//   bus (master)           : FIFO pops and SPI byte handshake
//   weight_tx_data_valid   : 1-cycle pulse per completed weight byte
//   act_in_tx_data_valid   : 1-cycle pulse per completed act-in byte
//   grant                  : one-hot {act, weight}, 00 when idle
//   tx_all_done            : both per-layer totals reached
// Build option: define ARB_STRICT_PRIO_EN for strict weight priority instead
// of round-robin.
module spi_tx_arbiter #(
  parameter int unsigned BURST_BYTES  = 16,
  parameter int unsigned WEIGHT_TOTAL = 1024,
  parameter int unsigned ACT_TOTAL    = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  spi_tx_arbiter_if.master bus,
  output logic             weight_tx_data_valid,
  output logic             act_in_tx_data_valid,
  output logic [1:0]       grant,
  output logic             tx_all_done
);
  localparam int unsigned WW = $clog2(WEIGHT_TOTAL + 1);
  localparam int unsigned AW = $clog2(ACT_TOTAL + 1);
  localparam int unsigned BW = $clog2(BURST_BYTES + 1);
  localparam logic [WW-1:0] W_TOT = WW'(WEIGHT_TOTAL);
  localparam logic [AW-1:0] A_TOT = AW'(ACT_TOTAL);
  localparam logic [BW-1:0] B_MAX = BW'(BURST_BYTES);
  localparam logic [1:0]    GRANT_W = 2'b01;
  localparam logic [1:0]    GRANT_A = 2'b10;
`ifdef ARB_STRICT_PRIO_EN
  localparam logic STRICT = 1'b1;
`else
  localparam logic STRICT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          ptr_q, ptr_d;        // 0: weight next, 1: act next
  logic [BW-1:0] burst_q, burst_d;
  logic [WW-1:0] w_cnt_q, w_cnt_d;
  logic [AW-1:0] a_cnt_q, a_cnt_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_start_q, tx_start_d;
  logic          w_pulse_q, w_pulse_d;
  logic          a_pulse_q, a_pulse_d;
  logic          all_done_q, all_done_d;

  logic          w_elig, a_elig, take_w;
  logic          src_w, src_valid, src_below;
  logic [7:0]    src_data;
  logic [WW-1:0] w_inc;
  logic [AW-1:0] a_inc;
  logic [BW-1:0] burst_inc;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    burst_d    = burst_q;
    w_cnt_d    = w_cnt_q;
    a_cnt_d    = a_cnt_q;
    tx_byte_d  = tx_byte_q;
    tx_start_d = 1'b0;
    w_pulse_d  = 1'b0;
    a_pulse_d  = 1'b0;
    bus.w_ready = 1'b0;
    bus.a_ready = 1'b0;

    w_elig    = bus.w_valid && (w_cnt_q < W_TOT);
    a_elig    = bus.a_valid && (a_cnt_q < A_TOT);
    take_w    = w_elig && (!a_elig || STRICT || !ptr_q);
    w_inc     = (w_cnt_q < W_TOT) ? w_cnt_q + 1'b1 : w_cnt_q;
    a_inc     = (a_cnt_q < A_TOT) ? a_cnt_q + 1'b1 : a_cnt_q;
    burst_inc = burst_q + 1'b1;
    src_w     = grant_q[0];
    src_valid = src_w ? bus.w_valid : bus.a_valid;
    src_data  = src_w ? bus.w_data  : bus.a_data;
    src_below = src_w ? (w_inc < W_TOT) : (a_inc < A_TOT);

    // Counters only move upward, so the flag can be recomputed every cycle;
    // clear masks it so it drops together with the counters.
    all_done_d = !clear && (w_cnt_q == W_TOT) && (a_cnt_q == A_TOT);

    if (clear) begin
      // A tx_done in this cycle is dropped; an in-flight byte is not recalled.
      state_d = IDLE;
      grant_d = '0;
      ptr_d   = 1'b0;
      burst_d = '0;
      w_cnt_d = '0;
      a_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable && (w_elig || a_elig)) begin
            grant_d = take_w ? GRANT_W : GRANT_A;
            burst_d = '0;
            state_d = LOAD;
          end
        end
        LOAD: begin
          if (src_valid) begin
            bus.w_ready = src_w;
            bus.a_ready = !src_w;
            tx_byte_d   = src_data;
            tx_start_d  = 1'b1;
            state_d     = WAIT;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
        WAIT: begin
          if (bus.tx_done) begin
            if (src_w) begin
              w_pulse_d = 1'b1;
              w_cnt_d   = w_inc;
            end else begin
              a_pulse_d = 1'b1;
              a_cnt_d   = a_inc;
            end
            burst_d = burst_inc;
            if ((burst_inc < B_MAX) && src_below && src_valid) begin
              state_d = LOAD;
            end else begin
              grant_d = '0;
              ptr_d   = src_w;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= 1'b0;
      burst_q    <= '0;
      w_cnt_q    <= '0;
      a_cnt_q    <= '0;
      tx_byte_q  <= '0;
      tx_start_q <= 1'b0;
      w_pulse_q  <= 1'b0;
      a_pulse_q  <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      burst_q    <= burst_d;
      w_cnt_q    <= w_cnt_d;
      a_cnt_q    <= a_cnt_d;
      tx_byte_q  <= tx_byte_d;
      tx_start_q <= tx_start_d;
      w_pulse_q  <= w_pulse_d;
      a_pulse_q  <= a_pulse_d;
      all_done_q <= all_done_d;
    end
  end

  assign bus.tx_byte           = tx_byte_q;
  assign bus.tx_start          = tx_start_q;
  assign grant                 = grant_q;
  assign weight_tx_data_valid  = w_pulse_q;
  assign act_in_tx_data_valid  = a_pulse_q;
  assign tx_all_done           = all_done_q;
endmodule

// File: tb/tb_spi_tx_arbiter.sv
module tb_spi_tx_arbiter;
  localparam int W_TOTAL = 8;
  localparam int A_TOTAL = 8;

  logic clk = 1'b0;
  logic rst, enable, clear;
  logic wv, av, all_done;
  logic [1:0] grant;

  spi_tx_arbiter_if bus ();

  spi_tx_arbiter #(.BURST_BYTES(4), .WEIGHT_TOTAL(W_TOTAL), .ACT_TOTAL(A_TOTAL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .bus(bus),
    .weight_tx_data_valid(wv), .act_in_tx_data_valid(av),
    .grant(grant), .tx_all_done(all_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Host FIFOs and SPI master stand-ins.
  logic [7:0] wq[$];
  logic [7:0] aq[$];
  int spi_cnt = 0;
  int clr_arm = 0;
  bit clr_auto = 0;
  bit wpop, apop;

  initial begin
    bus.w_valid = 0; bus.w_data = 0; bus.a_valid = 0; bus.a_data = 0; bus.tx_done = 0;
    forever begin
      @(negedge clk);
      wpop = bus.w_ready;
      apop = bus.a_ready;
      if (bus.tx_start) spi_cnt = 3;
      @(posedge clk); #1;
      if (wpop && wq.size() > 0) void'(wq.pop_front());
      if (apop && aq.size() > 0) void'(aq.pop_front());
      if (clr_auto) begin clear = 0; clr_auto = 0; end
      bus.tx_done = 0;
      if (spi_cnt > 0) begin
        spi_cnt--;
        if (spi_cnt == 0) begin
          bus.tx_done = 1;
          if (clr_arm > 0) begin
            clr_arm--;
            if (clr_arm == 0) begin clear = 1; clr_auto = 1; end
          end
        end
      end
      bus.w_valid = (wq.size() != 0);
      bus.w_data  = (wq.size() != 0) ? wq[0] : 8'h00;
      bus.a_valid = (aq.size() != 0);
      bus.a_data  = (aq.size() != 0) ? aq[0] : 8'h00;
    end
  end

  // Behavioural model: expected launch order ({is_act, byte}), per-source
  // byte counts, and the single outstanding SPI byte.
  logic [8:0] expq[$];
  bit go = 0;
  bit inflight = 0;
  bit inflight_act = 0;
  int wc = 0, ac = 0;
  bit exp_wv = 0, exp_av = 0, exp_all = 0, rst_prev = 0;
  int w_pulses = 0, a_pulses = 0;

  initial begin
    logic [8:0] e;
    wait (go);
    forever begin
      @(negedge clk);
      check("w_pulse", wv, exp_wv);
      check("a_pulse", av, exp_av);
      check("all_done", all_done, exp_all);
      if (rst_prev) begin
        check("rst_tx_byte", bus.tx_byte, 0);
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_grant", grant, 0);
        check("rst_ready", {bus.w_ready, bus.a_ready}, 0);
      end
      if (wv) w_pulses++;
      if (av) a_pulses++;
      if (bus.tx_start) begin
        check("one_in_flight", inflight, 0);
        if (expq.size() == 0) begin
          check("unexpected_start", 1, 0);
        end else begin
          e = expq.pop_front();
          check("tx_byte", bus.tx_byte, e[7:0]);
          check("start_grant", grant, e[8] ? 2'b10 : 2'b01);
          inflight_act = e[8];
        end
        inflight = 1;
      end
      exp_wv  = 0;
      exp_av  = 0;
      exp_all = !clear && !rst && (wc == W_TOTAL) && (ac == A_TOTAL);
      if (rst || clear) begin
        wc = 0; ac = 0; inflight = 0;
        expq.delete();
      end else if (bus.tx_done && inflight) begin
        inflight = 0;
        if (inflight_act) begin exp_av = 1; if (ac < A_TOTAL) ac++; end
        else begin exp_wv = 1; if (wc < W_TOTAL) wc++; end
      end
      rst_prev = rst;
    end
  end

  task automatic drive_edge(); @(posedge clk); #1; endtask
  task automatic tick(); @(negedge clk); #1; endtask

  task automatic do_clear();
    drive_edge(); clear = 1;
    drive_edge(); clear = 0;
  endtask

  task automatic wait_pulses(input int n, input int budget, input string name);
    int k = 0;
    while ((w_pulses + a_pulses) < n && k < budget) begin tick(); k++; end
    if ((w_pulses + a_pulses) < n) check({name, "_timeout"}, w_pulses + a_pulses, n);
  endtask

  task automatic push_w(input logic [7:0] b); wq.push_back(b); expq.push_back({1'b0, b}); endtask
  task automatic push_a(input logic [7:0] b); aq.push_back(b); expq.push_back({1'b1, b}); endtask

  initial begin
    int k;
    rst = 1; enable = 0; clear = 0;
    repeat (3) drive_edge();
    rst = 0;
    go = 1;
    tick();
    check("reset_w_ready", bus.w_ready, 0);
    check("reset_a_ready", bus.a_ready, 0);
    check("reset_tx_byte", bus.tx_byte, 0);
    check("reset_tx_start", bus.tx_start, 0);
    check("reset_pulses", {wv, av}, 0);
    check("reset_grant", grant, 0);
    check("reset_all_done", all_done, 0);

    // Both FIFOs hold 8 bytes: 4-byte bursts, alternating W,A,W,A.
    drive_edge();
    for (int i = 0; i < 8; i++) begin wq.push_back(8'h10 + 8'(i)); aq.push_back(8'hA0 + 8'(i)); end
`ifdef ARB_STRICT_PRIO_EN
    for (int i = 0; i < 8; i++) expq.push_back({1'b0, 8'h10 + 8'(i)});
    for (int i = 0; i < 8; i++) expq.push_back({1'b1, 8'hA0 + 8'(i)});
`else
    for (int blk = 0; blk < 2; blk++) begin
      for (int i = 0; i < 4; i++) expq.push_back({1'b0, 8'h10 + 8'(blk * 4 + i)});
      for (int i = 0; i < 4; i++) expq.push_back({1'b1, 8'hA0 + 8'(blk * 4 + i)});
    end
`endif
    repeat (3) drive_edge();
    w_pulses = 0; a_pulses = 0;
    enable = 1;
    tick();
    tick();
    check("lat_pop", bus.w_ready, 1);
    check("lat_grant", grant, 2'b01);
    tick();
    check("lat_start", bus.tx_start, 1);
    check("lat_byte", bus.tx_byte, 8'h10);
    wait_pulses(16, 400, "rr");
    check("rr_w_pulses", w_pulses, 8);
    check("rr_a_pulses", a_pulses, 8);
    check("all_done_not_yet", all_done, 0);
    tick();
    check("all_done_after_16", all_done, 1);
    check("rr_grant_idle", grant, 0);

    // Weight total saturates: 10 bytes queued, only 8 sent, then idle.
    enable = 0;
    do_clear();
    tick();
    check("clear_all_done", all_done, 0);
    drive_edge();
    w_pulses = 0; a_pulses = 0;
    for (int i = 0; i < 10; i++) wq.push_back(8'h30 + 8'(i));
    for (int i = 0; i < 8; i++) expq.push_back({1'b0, 8'h30 + 8'(i)});
    repeat (2) drive_edge();
    enable = 1;
    wait_pulses(8, 300, "sat");
    for (int i = 0; i < 12; i++) begin
      tick();
      check("sat_w_ready", bus.w_ready, 0);
      check("sat_grant", grant, 0);
    end
    check("sat_w_pulses", w_pulses, 8);
    check("sat_w_left", wq.size(), 2);

    // Weight FIFO runs dry after 2 bytes of the burst; grant moves to act.
    drive_edge();
    enable = 0;
    wq.delete();
    do_clear();
    w_pulses = 0; a_pulses = 0;
    push_w(8'h50); push_w(8'h51);
    for (int i = 0; i < 4; i++) push_a(8'h60 + 8'(i));
    repeat (2) drive_edge();
    enable = 1;
    k = 0;
    while (w_pulses < 2 && k < 100) begin tick(); k++; end
    check("dry_w_pulses", w_pulses, 2);
    check("dry_grant_idle", grant, 0);
    tick();
    check("dry_grant_act", grant, 2'b10);
    wait_pulses(6, 200, "dry");
    check("dry_a_pulses", a_pulses, 4);

    // clear coincident with tx_done of byte 3: no pulse, back to IDLE.
    drive_edge();
    enable = 0;
    do_clear();
    w_pulses = 0; a_pulses = 0;
    for (int i = 0; i < 4; i++) push_w(8'h70 + 8'(i));
    clr_arm = 3;
    repeat (2) drive_edge();
    enable = 1;
    k = 0;
    while (!bus.tx_start && k < 50) begin tick(); k++; end
    check("clr_first_start", bus.tx_start, 1);
    drive_edge();
    enable = 0;
    k = 0;
    while (clear !== 1'b1 && k < 100) begin tick(); k++; end
    check("clr_seen", clear, 1);
    tick();
    check("clr_no_pulse", wv, 0);
    check("clr_grant", grant, 0);
    check("clr_w_ready", bus.w_ready, 0);
    repeat (8) tick();
    check("clr_w_pulses", w_pulses, 2);
    check("clr_all_done", all_done, 0);

    // rst while waiting on SPI: reset values next cycle, late tx_done ignored.
    drive_edge();
    wq.delete();
    do_clear();
    push_w(8'h80);
    wq.push_back(8'h81); wq.push_back(8'h82);
    repeat (2) drive_edge();
    enable = 1;
    k = 0;
    while (!bus.tx_start && k < 50) begin tick(); k++; end
    check("rst_first_start", bus.tx_start, 1);
    check("rst_first_byte", bus.tx_byte, 8'h80);
    drive_edge();
    rst = 1; enable = 0;
    drive_edge();
    rst = 0;
    tick();
    check("rstw_tx_byte", bus.tx_byte, 0);
    check("rstw_tx_start", bus.tx_start, 0);
    check("rstw_grant", grant, 0);
    check("rstw_pulses", {wv, av}, 0);
    w_pulses = 0;
    repeat (8) tick();
    check("rstw_no_pulse", w_pulses, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
